// File: rtl/gpu_ram_arbiter_pkg.sv
// rtl/gpu_ram_arbiter_pkg.sv - shared types and constants for the GPU RAM arbiter
package gpu_mem_pkg;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 8;

   localparam logic REQ_GPU  = 1'b0;
   localparam logic REQ_SCAN = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

   // Burst counter stops at the limit so an uncontested owner never wraps.
   function automatic logic [3:0] sat_inc(input logic [3:0] cnt, input logic [3:0] lim);
      return (cnt >= lim) ? lim : cnt + 4'd1;
   endfunction

endpackage

// File: rtl/gpu_ram_arbiter_if.sv
// rtl/gpu_ram_arbiter_if.sv - requester and RAM-side signals of the arbiter
interface gpu_ram_arbiter_if #(
   parameter int ADDR_W = gpu_mem_pkg::DEF_ADDR_W,
   parameter int DATA_W = gpu_mem_pkg::DEF_DATA_W
);
   logic              req0, req1;
   logic              we0, we1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              gnt0, gnt1;
   logic              rvalid0, rvalid1;
   logic [DATA_W-1:0] rdata;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_store;
   logic              ram_load;
   logic [DATA_W-1:0] ram_rdata;

   // Requesters plus the RAM instance
   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata, ram_addr, ram_wdata, ram_store, ram_load
   );

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
      output gnt0, gnt1, rvalid0, rvalid1, rdata, ram_addr, ram_wdata, ram_store, ram_load
   );
endinterface

// File: rtl/gpu_ram_arbiter_rr_pick2.sv
// rtl/gpu_ram_arbiter_rr_pick2.sv - combinational two-way round-robin pick
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last,
   input  logic       lock,
   input  logic       lock_id,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      if (lock)
         gnt = lock_id ? 2'b10 : 2'b01;
      else if (&req)
         gnt = last ? 2'b01 : 2'b10;
      else
         gnt = req;
   end

endmodule

// File: rtl/gpu_ram_arbiter.sv
// rtl/gpu_ram_arbiter.sv - shares one RAM port between GPU core and scanout
module gpu_ram_arbiter
   import gpu_mem_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   gpu_ram_arbiter_if.slave bus
);

   localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

   arb_state_t        state, state_nxt;
   logic              last, last_nxt;
   logic [3:0]        cnt, cnt_nxt;
   logic [1:0]        rvalid_q, rvalid_nxt;
   logic [1:0]        req, gnt;
   logic              lock, lock_id;
   logic [ADDR_W-1:0] addr_mux;
   logic [DATA_W-1:0] wdata_mux;
   logic              store_mux, load_mux;

   // Requests are masked during reset so no grant or RAM strobe can leak out.
   assign req     = {bus.req1, bus.req0} & {2{rst_n}};
   assign lock_id = (state == OWN1);
   assign lock    = ((state == OWN0) && req[REQ_GPU]  && ((cnt < MAX_CNT) || !req[REQ_SCAN])) ||
                    ((state == OWN1) && req[REQ_SCAN] && ((cnt < MAX_CNT) || !req[REQ_GPU]));

   rr_pick2 u_pick (
      .req     (req),
      .last    (last),
      .lock    (lock),
      .lock_id (lock_id),
      .gnt     (gnt)
   );

   always_comb begin
      state_nxt  = IDLE;
      cnt_nxt    = 4'd0;
      last_nxt   = last;
      rvalid_nxt = gnt & ~{bus.we1, bus.we0};
      if (gnt[REQ_GPU]) begin
         state_nxt = OWN0;
         last_nxt  = REQ_GPU;
         cnt_nxt   = (state == OWN0) ? sat_inc(cnt, MAX_CNT) : 4'd1;
      end else if (gnt[REQ_SCAN]) begin
         state_nxt = OWN1;
         last_nxt  = REQ_SCAN;
         cnt_nxt   = (state == OWN1) ? sat_inc(cnt, MAX_CNT) : 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         last     <= REQ_SCAN;
         cnt      <= 4'd0;
         rvalid_q <= 2'b00;
      end else begin
         state    <= state_nxt;
         last     <= last_nxt;
         cnt      <= cnt_nxt;
         rvalid_q <= rvalid_nxt;
      end
   end

   // With no grant the port idles on requester 0's address and data.
   always_comb begin
      addr_mux  = bus.addr0;
      wdata_mux = bus.wdata0;
      store_mux = 1'b0;
      load_mux  = 1'b0;
      if (gnt[REQ_SCAN]) begin
         addr_mux  = bus.addr1;
         wdata_mux = bus.wdata1;
         store_mux = bus.we1;
         load_mux  = !bus.we1;
      end else if (gnt[REQ_GPU]) begin
         store_mux = bus.we0;
         load_mux  = !bus.we0;
      end
   end

   assign bus.gnt0      = gnt[REQ_GPU];
   assign bus.gnt1      = gnt[REQ_SCAN];
   assign bus.rvalid0   = rvalid_q[REQ_GPU];
   assign bus.rvalid1   = rvalid_q[REQ_SCAN];
   assign bus.rdata     = bus.ram_rdata;
   assign bus.ram_addr  = addr_mux;
   assign bus.ram_wdata = wdata_mux;
   assign bus.ram_store = store_mux;
   assign bus.ram_load  = load_mux;

endmodule
